// File: rtl/kp_matrix_scanner_pkg.sv
// kp_pkg: shared state, event and constant definitions for the keypad matrix scanner
package kp_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, EMIT} kp_state_t;
    localparam int KP_CODE_MAX_W = 16;
    localparam logic [31:0] KP_ROW_IDLE = '1;
    typedef struct packed {
        logic [KP_CODE_MAX_W-1:0] code;
        logic                     press;
    } kp_evt_t;
    function automatic int kp_key_w(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction
endpackage

// File: rtl/kp_matrix_scanner_if.sv
// kp_matrix_scanner_if: press/release event stream with valid/ready handshake and sticky overflow
interface kp_matrix_scanner_if #(
    parameter int CW = kp_pkg::kp_key_w(4, 4)
);
    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] evt_code;
    logic          evt_press;
    logic          evt_overflow;
    modport master(output evt_valid, evt_code, evt_press, evt_overflow, input evt_ready);
    modport slave(input evt_valid, evt_code, evt_press, evt_overflow, output evt_ready);
endinterface

// File: rtl/kp_matrix_scanner_fifo.sv
// kp_event_fifo: first-word-fall-through FIFO that drops pushes when full and flags it stickily
module kp_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [NW-1:0] cnt_q;
    logic          full, do_push, do_pop, drop_q;
    assign full    = cnt_q == NW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_q];
    assign drop_o  = drop_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            wr_q   <= wr_q + AW'(do_push);
            rd_q   <= rd_q + AW'(do_pop);
            cnt_q  <= cnt_q + NW'(do_push) - NW'(do_pop);
            drop_q <= drop_q | (push_i && !do_push);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/kp_matrix_scanner.sv
// kp_matrix_scanner: scans an active-low key matrix, debounces every key and queues press/release events
module kp_matrix_scanner
    import kp_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scan_en_i,
    input  logic [COLS-1:0]      kp_col_i,
    output logic [ROWS-1:0]      kp_row_o,
    output logic [ROWS*COLS-1:0] key_state_o,
    kp_matrix_scanner_if.master  evt
);
    localparam int N   = ROWS * COLS;
    localparam int CW  = kp_key_w(ROWS, COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int SW  = $clog2(SETTLE_CYCLES);
    localparam int DW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int CSW = COLS > 1 ? $clog2(COLS) : 1;
    kp_state_t      state_q, state_d;
    logic [RW-1:0]  row_q, row_d, row_nx;
    logic [SW-1:0]  set_q, set_d;
    logic [COLS-1:0] chg_q, chg_d, chg_s;
    logic [COLS-1:0] sync1_q, sync2_q;
    logic [N-1:0]   ks_q, ks_d;
    logic [DW-1:0]  deb_q [N];
    logic [DW-1:0]  deb_d [N];
    logic [CSW-1:0] sel;
    logic [CW-1:0]  code;
    logic           empty;
    kp_evt_t        pe, head;
    assign row_nx      = row_q == RW'(ROWS - 1) ? '0 : row_q + 1'b1;
    assign kp_row_o    = state_q == IDLE ? ROWS'(KP_ROW_IDLE) : ~(ROWS'(1) << row_q);
    assign key_state_o = ks_q;
    assign code        = CW'(int'(row_q) * COLS + int'(sel));
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            state_q <= IDLE;
            row_q   <= '0;
            set_q   <= '0;
            chg_q   <= '0;
            ks_q    <= '0;
            deb_q   <= '{default: '0};
        end else begin
            sync1_q <= kp_col_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            row_q   <= row_d;
            set_q   <= set_d;
            chg_q   <= chg_d;
            ks_q    <= ks_d;
            deb_q   <= deb_d;
        end
    end
    // A synchronised 1 on a column means released; the key disagrees with its stable state when that equals it
    always_comb begin
        ks_d  = ks_q;
        deb_d = deb_q;
        chg_s = '0;
        for (int k = 0; k < N; k++) begin
            if (state_q == SAMPLE && k / COLS == int'(row_q)) begin
                if (sync2_q[k % COLS] != ks_q[k]) deb_d[k] = '0;
                else if (deb_q[k] == DW'(DEBOUNCE_SCANS - 1)) begin
                    deb_d[k]          = '0;
                    ks_d[k]           = ~ks_q[k];
                    chg_s[k % COLS]   = 1'b1;
                end else deb_d[k] = deb_q[k] + 1'b1;
            end
        end
    end
    always_comb begin
        sel = '0;
        for (int c = COLS - 1; c >= 0; c--) if (chg_q[c]) sel = CSW'(c);
    end
    always_comb begin
        pe.code  = KP_CODE_MAX_W'(code);
        pe.press = ks_q[code];
    end
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        set_d   = set_q;
        chg_d   = chg_q;
        if (!scan_en_i) begin
            state_d = IDLE;
            row_d   = '0;
            chg_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = DRIVE;
                    row_d   = '0;
                    set_d   = '0;
                end
                DRIVE: begin
                    state_d = set_q == SW'(SETTLE_CYCLES - 1) ? SAMPLE : DRIVE;
                    set_d   = set_q + 1'b1;
                end
                SAMPLE: begin
                    chg_d   = chg_s;
                    state_d = |chg_s ? EMIT : DRIVE;
                    row_d   = |chg_s ? row_q : row_nx;
                    set_d   = '0;
                end
                EMIT: begin
                    chg_d   = chg_q & ~(COLS'(1) << sel);
                    state_d = |chg_d ? EMIT : DRIVE;
                    row_d   = |chg_d ? row_q : row_nx;
                    set_d   = '0;
                end
            endcase
        end
    end
    kp_event_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W($bits(kp_evt_t))
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(state_q == EMIT),
        .data_i(pe),
        .pop_i(evt.evt_ready),
        .data_o(head),
        .empty_o(empty),
        .drop_o(evt.evt_overflow)
    );
    assign evt.evt_valid = !empty;
    assign evt.evt_code  = CW'(head.code);
    assign evt.evt_press = head.press;
endmodule
